// File: rtl/core_scheduler.sv
// Per-core instruction scheduler: steps FETCH..UPDATE and waits on the busy lanes' LSUs.
// Optional watchdog abort out of WAIT is enabled by defining SCHED_WATCHDOG_EN.
module core_scheduler #(
    parameter int THREADS = 4,
    parameter int PC_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [3:0]              thread_count,
    input  logic [2:0]              fetcher_state,
    input  logic                    decoded_mem_read_enable,
    input  logic                    decoded_mem_write_enable,
    input  logic                    decoded_ret,
    input  logic [2*THREADS-1:0]    lsu_state,
    input  logic [PC_W*THREADS-1:0] next_pc,
    output logic [2:0]              core_state,
    output logic [PC_W-1:0]         current_pc,
    output logic                    done,
    output logic                    error
);

    localparam logic [2:0] FETCHED = 3'b010;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        FETCH   = 3'b001,
        DECODE  = 3'b010,
        REQUEST = 3'b011,
        WAIT    = 3'b100,
        EXECUTE = 3'b101,
        UPDATE  = 3'b110,
        DONE    = 3'b111
    } state_t;

    state_t          state_q;
    logic [PC_W-1:0] pc_q;
    logic            done_q;
    logic            lanes_busy_c;
    logic [PC_W-1:0] pc_sel_c;
    logic            unused_mem_info;

    // Memory-instruction flags do not change the WAIT exit condition.
    assign unused_mem_info = decoded_mem_read_enable | decoded_mem_write_enable;

    // Busy = any active lane still requesting or waiting; next PC comes from the last active lane.
    always_comb begin
        lanes_busy_c = 1'b0;
        pc_sel_c     = next_pc[PC_W-1:0];
        for (int i = 0; i < THREADS; i++) begin
            if ((4'(i) < thread_count) &&
                ((lsu_state[2*i +: 2] == 2'b01) || (lsu_state[2*i +: 2] == 2'b10)))
                lanes_busy_c = 1'b1;
            if (4'(i) == (thread_count - 4'd1))
                pc_sel_c = next_pc[PC_W*i +: PC_W];
        end
    end

`ifdef SCHED_WATCHDOG_EN
    logic [7:0] wd_count_q;
    logic       error_q;
    logic       wd_expire_c;

    assign wd_expire_c = (state_q == WAIT) && lanes_busy_c && (wd_count_q == 8'd254);

    // Counts WAIT cycles; the 255th busy WAIT cycle aborts the block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_count_q <= 8'd0;
            error_q    <= 1'b0;
        end else begin
            if (state_q == REQUEST)
                wd_count_q <= 8'd0;
            else if (state_q == WAIT)
                wd_count_q <= wd_count_q + 8'd1;
            if (wd_expire_c)
                error_q <= 1'b1;
            else if ((state_q == DONE) && !start)
                error_q <= 1'b0;
        end
    end

    assign error = error_q;
`else
    logic wd_expire_c;

    assign wd_expire_c = 1'b0;
    assign error       = 1'b0;
`endif

    // Scheduler state machine; every output is a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FETCH;
                        pc_q    <= '0;
                    end
                end
                FETCH: begin
                    if (fetcher_state == FETCHED)
                        state_q <= DECODE;
                end
                DECODE:  state_q <= REQUEST;
                REQUEST: state_q <= WAIT;
                WAIT: begin
                    if (!lanes_busy_c) begin
                        state_q <= EXECUTE;
                    end else if (wd_expire_c) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                EXECUTE: state_q <= UPDATE;
                UPDATE: begin
                    if (decoded_ret) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= FETCH;
                        pc_q    <= pc_sel_c;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign core_state = state_q;
    assign current_pc = pc_q;
    assign done       = done_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Scoreboard bench for core_scheduler: stimulus queues expected outputs, a negedge monitor checks them.
module tb_core_scheduler;

    localparam int THREADS = 4;
    localparam int PC_W    = 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_REQUEST = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_EXECUTE = 3'd5;
    localparam logic [2:0] S_UPDATE  = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    start;
    logic [3:0]              thread_count;
    logic [2:0]              fetcher_state;
    logic                    decoded_mem_read_enable;
    logic                    decoded_mem_write_enable;
    logic                    decoded_ret;
    logic [2*THREADS-1:0]    lsu_state;
    logic [PC_W*THREADS-1:0] next_pc;
    logic [2:0]              core_state;
    logic [PC_W-1:0]         current_pc;
    logic                    done;
    logic                    error;

    typedef struct {
        logic [2:0]      st;
        logic [PC_W-1:0] pc;
        logic            d;
        logic            e;
        string           nm;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    core_scheduler #(.THREADS(THREADS), .PC_W(PC_W)) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .start                    (start),
        .thread_count             (thread_count),
        .fetcher_state            (fetcher_state),
        .decoded_mem_read_enable  (decoded_mem_read_enable),
        .decoded_mem_write_enable (decoded_mem_write_enable),
        .decoded_ret              (decoded_ret),
        .lsu_state                (lsu_state),
        .next_pc                  (next_pc),
        .core_state               (core_state),
        .current_pc               (current_pc),
        .done                     (done),
        .error                    (error)
    );

    task automatic expect_now(input logic [2:0] st, input logic [PC_W-1:0] pc,
                              input logic d, input logic e, input string nm);
        exp_t x;
        x.st = st;
        x.pc = pc;
        x.d  = d;
        x.e  = e;
        x.nm = nm;
        sb.push_back(x);
    endtask

    // Immediate comparison of the outputs against the required values.
    task automatic check_now(input logic [2:0] st, input logic [PC_W-1:0] pc,
                             input logic d, input logic e, input string nm);
        total++;
        if (core_state !== st || current_pc !== pc || done !== d || error !== e)
            $display("FAIL %s: got state=%0d pc=%0h done=%0b error=%0b, required state=%0d pc=%0h done=%0b error=%0b",
                     nm, core_state, current_pc, done, error, st, pc, d, e);
        else
            passed++;
    endtask

    // One clock edge with the current inputs, then queue the outputs expected after it.
    task automatic step(input logic [2:0] st, input logic [PC_W-1:0] pc,
                        input logic d, input logic e, input string nm);
        @(posedge clk);
        #1;
        expect_now(st, pc, d, e, nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t x;
        if (sb.size() != 0) begin
            x = sb.pop_front();
            total++;
            if (core_state !== x.st || current_pc !== x.pc || done !== x.d || error !== x.e)
                $display("FAIL %s: got state=%0d pc=%0h done=%0b error=%0b, required state=%0d pc=%0h done=%0b error=%0b",
                         x.nm, core_state, current_pc, done, error, x.st, x.pc, x.d, x.e);
            else
                passed++;
        end
    end

    initial begin
        reset_n                  = 1'b0;
        start                    = 1'b0;
        thread_count             = 4'd4;
        fetcher_state            = 3'b000;
        decoded_mem_read_enable  = 1'b0;
        decoded_mem_write_enable = 1'b0;
        decoded_ret              = 1'b0;
        lsu_state                = '0;
        next_pc                  = {8'h01, 8'h22, 8'h11, 8'hAA};

        #1;
        check_now(S_IDLE, 8'h00, 1'b0, 1'b0, "reset_state_async");
        step(S_IDLE, 8'h00, 1'b0, 1'b0, "reset_state");
        reset_n = 1'b1;
        start   = 1'b1;

        // Basic non-memory instruction, fetch completes after 3 extra cycles.
        for (int i = 0; i < 4; i++) step(S_FETCH, 8'h00, 1'b0, 1'b0, "s1_fetch_hold");
        fetcher_state = 3'b010;
        step(S_DECODE, 8'h00, 1'b0, 1'b0, "s1_decode");
        fetcher_state = 3'b000;
        step(S_REQUEST, 8'h00, 1'b0, 1'b0, "s1_request");
        step(S_WAIT,    8'h00, 1'b0, 1'b0, "s1_wait");
        step(S_EXECUTE, 8'h00, 1'b0, 1'b0, "s1_execute_1cyc_wait");
        step(S_UPDATE,  8'h00, 1'b0, 1'b0, "s1_update");
        step(S_FETCH,   8'h01, 1'b0, 1'b0, "s1_next_pc_lane3");

        // Lane 2 busy in WAIT: five WAIT cycles, then EXECUTE.
        next_pc[31:24] = 8'h05;
        decoded_mem_read_enable = 1'b1;
        fetcher_state = 3'b010;
        step(S_DECODE, 8'h01, 1'b0, 1'b0, "s2_decode");
        fetcher_state = 3'b000;
        step(S_REQUEST, 8'h01, 1'b0, 1'b0, "s2_request");
        lsu_state[5:4] = 2'b10;
        step(S_WAIT, 8'h01, 1'b0, 1'b0, "s2_wait_entry");
        for (int i = 0; i < 4; i++) step(S_WAIT, 8'h01, 1'b0, 1'b0, "s2_wait_busy");
        lsu_state[5:4] = 2'b11;
        step(S_EXECUTE, 8'h01, 1'b0, 1'b0, "s2_execute_after_5");
        lsu_state = '0;
        decoded_mem_read_enable = 1'b0;
        step(S_UPDATE, 8'h01, 1'b0, 1'b0, "s2_update");
        step(S_FETCH,  8'h05, 1'b0, 1'b0, "s2_next_pc");

        // Two active threads: stuck lane 3 ignored, PC from lane 1.
        thread_count   = 4'd2;
        lsu_state[7:6] = 2'b01;
        fetcher_state  = 3'b010;
        step(S_DECODE, 8'h05, 1'b0, 1'b0, "s3_decode");
        fetcher_state = 3'b000;
        step(S_REQUEST, 8'h05, 1'b0, 1'b0, "s3_request");
        step(S_WAIT,    8'h05, 1'b0, 1'b0, "s3_wait");
        step(S_EXECUTE, 8'h05, 1'b0, 1'b0, "s3_ignore_lane3");
        step(S_UPDATE,  8'h05, 1'b0, 1'b0, "s3_update");
        step(S_FETCH,   8'h11, 1'b0, 1'b0, "s3_pc_lane1");

        // Return: DONE holds while start=1, IDLE once start drops.
        thread_count  = 4'd4;
        lsu_state     = '0;
        fetcher_state = 3'b010;
        step(S_DECODE, 8'h11, 1'b0, 1'b0, "s4_decode");
        fetcher_state = 3'b000;
        step(S_REQUEST, 8'h11, 1'b0, 1'b0, "s4_request");
        step(S_WAIT,    8'h11, 1'b0, 1'b0, "s4_wait");
        step(S_EXECUTE, 8'h11, 1'b0, 1'b0, "s4_execute");
        decoded_ret = 1'b1;
        step(S_UPDATE, 8'h11, 1'b0, 1'b0, "s4_update");
        step(S_DONE,   8'h11, 1'b1, 1'b0, "s4_ret_done");
        decoded_ret = 1'b0;
        step(S_DONE, 8'h11, 1'b1, 1'b0, "s4_done_held");
        start = 1'b0;
        step(S_IDLE, 8'h11, 1'b0, 1'b0, "s4_idle_done_clr");
        step(S_IDLE, 8'h11, 1'b0, 1'b0, "s4_idle_hold");
        start = 1'b1;
        step(S_FETCH, 8'h00, 1'b0, 1'b0, "s4_restart_pc0");

        // Asynchronous reset in the middle of WAIT.
        fetcher_state = 3'b010;
        step(S_DECODE, 8'h00, 1'b0, 1'b0, "s5_decode");
        fetcher_state = 3'b000;
        step(S_REQUEST, 8'h00, 1'b0, 1'b0, "s5_request");
        lsu_state[1:0] = 2'b10;
        tick();
        #1;
        reset_n = 1'b0;
        expect_now(S_IDLE, 8'h00, 1'b0, 1'b0, "s5_async_reset");
        @(negedge clk);
        #1;
        reset_n   = 1'b1;
        start     = 1'b0;
        lsu_state = '0;
        step(S_IDLE, 8'h00, 1'b0, 1'b0, "s5_idle_needs_start");
        start = 1'b1;
        step(S_FETCH, 8'h00, 1'b0, 1'b0, "s5_restart");

        // Lane 0 stuck waiting forever.
        fetcher_state = 3'b010;
        step(S_DECODE, 8'h00, 1'b0, 1'b0, "s6_decode");
        fetcher_state = 3'b000;
        step(S_REQUEST, 8'h00, 1'b0, 1'b0, "s6_request");
        lsu_state[1:0] = 2'b10;
        step(S_WAIT, 8'h00, 1'b0, 1'b0, "s6_wait_entry");
`ifdef SCHED_WATCHDOG_EN
        for (int i = 0; i < 254; i++) step(S_WAIT, 8'h00, 1'b0, 1'b0, "s6_wd_waiting");
        step(S_DONE, 8'h00, 1'b1, 1'b1, "s6_wd_abort");
        check_now(S_DONE, 8'h00, 1'b1, 1'b1, "s6_wd_expired");
        start = 1'b0;
        step(S_IDLE, 8'h00, 1'b0, 1'b0, "s6_wd_error_clr");
`else
        for (int i = 0; i < 300; i++) step(S_WAIT, 8'h00, 1'b0, 1'b0, "s6_no_wd_waiting");
        check_now(S_WAIT, 8'h00, 1'b0, 1'b0, "s6_no_wd_still_waiting");
        lsu_state = '0;
        step(S_EXECUTE, 8'h00, 1'b0, 1'b0, "s6_release");
        decoded_ret = 1'b1;
        step(S_UPDATE, 8'h00, 1'b0, 1'b0, "s6_update");
        step(S_DONE,   8'h00, 1'b1, 1'b0, "s6_done_no_error");
        decoded_ret = 1'b0;
        start       = 1'b0;
        step(S_IDLE, 8'h00, 1'b0, 1'b0, "s6_idle");
`endif

        repeat (3) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/core_scheduler.md
CORE_SCHEDULER -- requirements
Module: core_scheduler

Interface
REQ-001 The block SHALL have parameter THREADS, default 4, giving the number of threads per core (1..8).
REQ-002 The block SHALL have parameter PC_W, default 8, giving the program counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level request to begin or continue executing a block from PC 0.
REQ-006 thread_count  input  4  number of active threads, 1..THREADS; lanes at or above this count are ignored.
REQ-007 fetcher_state  input  3  instruction fetcher state; 3'b010 = FETCHED.
REQ-008 decoded_mem_read_enable, decoded_mem_write_enable, decoded_ret  input  1 each  decoder controls for the current instruction.
REQ-009 lsu_state  input  2*THREADS  packed per-lane LSU state; 00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE.
REQ-010 next_pc  input  PC_W*THREADS  packed per-lane next PC from the PC units.
REQ-011 core_state  output  3  current scheduler state, broadcast to the fetcher, decoder, ALUs, LSUs and PC units.
REQ-012 current_pc  output  PC_W  PC of the instruction in flight.
REQ-013 done  output  1  block finished.
REQ-014 error  output  1  watchdog abort flag.

Function
REQ-015 The block SHALL encode core_state as follows: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
REQ-016 IDLE SHALL transition to FETCH when start=1, loading current_pc=0 on the same edge; otherwise IDLE SHALL hold.
REQ-017 FETCH SHALL hold until fetcher_state==3'b010, then SHALL transition to DECODE.
REQ-018 DECODE, REQUEST and EXECUTE SHALL each last exactly one cycle: DECODE->REQUEST, REQUEST->WAIT, EXECUTE->UPDATE.
REQ-019 WAIT SHALL transition to EXECUTE in the first cycle in which no lane below thread_count has lsu_state 01 or 10; lanes at or above thread_count SHALL be ignored.
REQ-020 WAIT SHALL be evaluated from its first cycle, so WAIT lasts exactly 1 cycle when no lane is busy (for example, a non-memory instruction).
REQ-021 In UPDATE with decoded_ret=1, the block SHALL transition to DONE, set done=1 and leave current_pc unchanged.
REQ-022 In UPDATE with decoded_ret=0, the block SHALL load current_pc from next_pc lane (thread_count-1) and transition to FETCH.
REQ-023 In DONE, done=1 SHALL be held while start=1; when start=0 the block SHALL transition to IDLE and clear done (and error) on that edge.
REQ-024 Minimum instruction latency SHALL be 6 cycles, FETCH through UPDATE, with a 1-cycle FETCH and 1-cycle WAIT.
REQ-025 The block SHALL treat decoded_mem_* as informational only; the WAIT exit condition SHALL be identical for memory and non-memory instructions.
REQ-026 current_pc SHALL wrap modulo 2^PC_W with no special handling.
REQ-027 All outputs SHALL be registered; no combinational path SHALL exist from any input to any output.

Reset
REQ-028 Asserting reset_n=0 SHALL immediately, without waiting for clk, force core_state=IDLE, current_pc=0, done=0, error=0 and the watchdog count=0.
REQ-029 Reset asserted in any state, including mid-WAIT, SHALL abandon the instruction; after release the block SHALL require start=1 to leave IDLE.

Configuration
REQ-030 With SCHED_WATCHDOG_EN defined, the block SHALL contain an 8-bit counter that clears on entry to WAIT and increments each cycle spent in WAIT.
REQ-031 With SCHED_WATCHDOG_EN defined, if the counter reaches 255 while still in WAIT, the block SHALL go to DONE and set done=1 and error=1.
REQ-032 Without SCHED_WATCHDOG_EN, no counter SHALL exist, error SHALL be tied to 0, and WAIT SHALL wait indefinitely.

Verification
REQ-033 The bench SHALL cover: reset release, start=1, thread_count=4, fetcher FETCHED after 3 cycles, all lsu IDLE, next_pc lane3=1 -> core_state sequence 001x4,010,011,100,101,110, then current_pc=1 and state FETCH.
REQ-034 The bench SHALL cover: lane 2 lsu_state=10 for 5 WAIT cycles then 11 -> WAIT lasts 5 cycles, with EXECUTE in the 6th.
REQ-035 The bench SHALL cover: thread_count=2, lane 3 stuck at 01 -> WAIT lasts 1 cycle, and current_pc takes next_pc lane1.
REQ-036 The bench SHALL cover: decoded_ret=1 in UPDATE -> DONE, done=1, current_pc unchanged; start dropped -> IDLE, done=0 next edge.
REQ-037 The bench SHALL cover: reset_n pulsed low mid-WAIT between clock edges -> outputs IDLE/0/0/0 before the next edge.
REQ-038 With SCHED_WATCHDOG_EN, the bench SHALL cover: lane 0 held at 10 forever -> after 255 WAIT cycles state=DONE, error=1; without the macro, error stays 0 and the block stays in WAIT.
